// File: rtl/vc_trace_streamer_if.sv
// vc_trace_streamer_if: line-in / character-out handshake bundle for the
// trace streamer. The streamer attaches through the slave modport; the
// producer of trace lines and the byte sink share the master modport.
// p_nchars must match the parameter of the streamer it connects to.

interface vc_trace_streamer_if #(
   parameter int p_nchars = 512
);

   // Line input side: one packed trace line per transaction
   logic                    line_val;
   logic                    line_rdy;
   logic [p_nchars*8-1:0]   line_msg;

   // Character output side: one ASCII byte per transaction
   logic                    out_val;
   logic                    out_rdy;
   logic [7:0]              out_msg;

   modport master (
      output line_val,
      output line_msg,
      output out_rdy,
      input  line_rdy,
      input  out_val,
      input  out_msg
   );

   modport slave (
      input  line_val,
      input  line_msg,
      input  out_rdy,
      output line_rdy,
      output out_val,
      output out_msg
   );

endinterface

// File: rtl/vc_trace_streamer.sv
// vc_trace_streamer: accepts one packed line-trace string per line
// transaction and replays it as a byte-serial character stream, ending every
// line with a newline (0x0A).
//
// Packed line layout: byte k lives at line_msg[k*8+:8], the first character
// is byte p_nchars-1, and line_msg[31:0] holds the write index (next free
// byte). Characters are emitted from byte p_nchars-1 down to byte end+1.
//
// Optional feature macro: VC_TRACE_STREAMER_LINENUM_EN
//   When defined, every line is prefixed with "hhhh: " where hhhh is a 16-bit
//   wrapping line number (lowercase hex, first line after reset is 0000).

module vc_trace_streamer #(
   parameter int p_nchars = 512
) (
   input logic               clk,
   input logic               reset,
   vc_trace_streamer_if.slave bus
);

   // Pointer wide enough to address every byte of the line buffer
   localparam int PW = $clog2(p_nchars);
   localparam logic [PW-1:0] LAST_BYTE = PW'(p_nchars - 1);
   localparam logic [PW-1:0] MIN_END   = PW'(3);

   // FSM encoding
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_BODY = 2'd2;
   localparam logic [1:0] S_EOL  = 2'd3;
`ifdef VC_TRACE_STREAMER_LINENUM_EN
   localparam logic [1:0] S_HDR  = 2'd1;
   localparam logic [2:0] HDR_LAST = 3'd5;
`endif

   localparam logic [7:0] CH_NL    = 8'h0A;
`ifdef VC_TRACE_STREAMER_LINENUM_EN
   localparam logic [7:0] CH_COLON = 8'h3A;
   localparam logic [7:0] CH_SPACE = 8'h20;
`endif

   logic [1:0]              state_q, state_d;
   logic [p_nchars*8-1:0]   buf_q;
   logic [PW-1:0]           ptr_q, ptr_d;
   logic [PW-1:0]           end_q, end_d;

   logic                    line_fire;
   logic                    char_fire;
   logic [31:0]             fire_idx;
   logic [PW-1:0]           fire_end;
   logic                    fire_empty;
   logic                    line_empty;
   logic                    last_body_char;
   logic [7:0]              body_char;

`ifdef VC_TRACE_STREAMER_LINENUM_EN
   logic [15:0]             cnt_q, cnt_d;
   logic [15:0]             hdr_num_q, hdr_num_d;
   logic [2:0]              hdr_pos_q, hdr_pos_d;
   logic [3:0]              hdr_nib;
   logic [7:0]              hdr_char;
`endif

   // Handshake outputs: only IDLE takes a line, every other state drives a char
   assign bus.line_rdy = (state_q == S_IDLE) && !reset;
   assign bus.out_val  = (state_q != S_IDLE);

   assign line_fire = bus.line_val && bus.line_rdy;
   assign char_fire = bus.out_val && bus.out_rdy;

   assign fire_idx = bus.line_msg[31:0];

   // Last index that is NOT emitted: bytes 0..3 always hold the index field,
   // and an index at or beyond the top byte means an empty line
   // NOTE: every signal written in always_comb gets a default first, so no
   // path can leave it unassigned and infer a latch.
   always_comb begin
      fire_end = fire_idx[PW-1:0];
      if (fire_idx >= 32'(p_nchars - 1)) begin
         fire_end = LAST_BYTE;
      end else if (fire_idx < 32'd3) begin
         fire_end = MIN_END;
      end
   end

   assign fire_empty     = (fire_end == LAST_BYTE);
   assign line_empty     = (end_q == LAST_BYTE);
   assign last_body_char = (ptr_q == end_q + PW'(1));
   assign body_char      = buf_q[{ptr_q, 3'b000} +: 8];

`ifdef VC_TRACE_STREAMER_LINENUM_EN
   // Header nibble for the current header position, most significant first
   always_comb begin
      hdr_nib = 4'h0;
      case (hdr_pos_q)
         3'd0:    hdr_nib = hdr_num_q[15:12];
         3'd1:    hdr_nib = hdr_num_q[11:8];
         3'd2:    hdr_nib = hdr_num_q[7:4];
         3'd3:    hdr_nib = hdr_num_q[3:0];
         default: hdr_nib = 4'h0;
      endcase
   end

   // Header character: four lowercase hex digits, then ':' and ' '
   always_comb begin
      hdr_char = 8'h00;
      if (hdr_pos_q == 3'd4) begin
         hdr_char = CH_COLON;
      end else if (hdr_pos_q == HDR_LAST) begin
         hdr_char = CH_SPACE;
      end else if (hdr_nib < 4'd10) begin
         hdr_char = 8'h30 + {4'h0, hdr_nib};
      end else begin
         hdr_char = 8'h61 + {4'h0, hdr_nib} - 8'd10;
      end
   end
`endif

   // Output character mux; state alone selects the source so the byte holds
   // steady for as long as the sink stalls
   always_comb begin
      bus.out_msg = 8'h00;
      case (state_q)
`ifdef VC_TRACE_STREAMER_LINENUM_EN
         S_HDR:   bus.out_msg = hdr_char;
`endif
         S_BODY:  bus.out_msg = body_char;
         S_EOL:   bus.out_msg = CH_NL;
         default: bus.out_msg = 8'h00;
      endcase
   end

   // Next-state logic: line fire loads a new line, char fire advances it
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      end_d   = end_q;
`ifdef VC_TRACE_STREAMER_LINENUM_EN
      hdr_pos_d = hdr_pos_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (line_fire) begin
               ptr_d = LAST_BYTE;
               end_d = fire_end;
`ifdef VC_TRACE_STREAMER_LINENUM_EN
               hdr_pos_d = 3'd0;
               state_d   = S_HDR;
`else
               state_d = fire_empty ? S_EOL : S_BODY;
`endif
            end
         end
`ifdef VC_TRACE_STREAMER_LINENUM_EN
         S_HDR: begin
            if (char_fire) begin
               hdr_pos_d = hdr_pos_q + 3'd1;
               if (hdr_pos_q == HDR_LAST) begin
                  state_d = line_empty ? S_EOL : S_BODY;
               end
            end
         end
`endif
         S_BODY: begin
            if (char_fire) begin
               ptr_d = ptr_q - PW'(1);
               if (last_body_char) begin
                  state_d = S_EOL;
               end
            end
         end
         S_EOL: begin
            if (char_fire) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Control state registers with synchronous reset
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         ptr_q   <= LAST_BYTE;
         end_q   <= LAST_BYTE;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         end_q   <= end_d;
      end
   end

   // Line buffer captured on line fire only
   // NOTE: the buffer is pure datapath and is never read before a line fire
   // loads it, so it carries no reset.
   always_ff @(posedge clk) begin
      if (line_fire) begin
         buf_q <= bus.line_msg;
      end
   end

`ifdef VC_TRACE_STREAMER_LINENUM_EN
   // Line counter and the number latched for the line being streamed
   always_comb begin
      cnt_d     = cnt_q;
      hdr_num_d = hdr_num_q;
      if (line_fire) begin
         cnt_d     = cnt_q + 16'd1;
         hdr_num_d = cnt_q;
      end
   end

   // Header registers with synchronous reset
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q     <= 16'h0000;
         hdr_num_q <= 16'h0000;
         hdr_pos_q <= 3'd0;
      end else begin
         cnt_q     <= cnt_d;
         hdr_num_q <= hdr_num_d;
         hdr_pos_q <= hdr_pos_d;
      end
   end
`endif

   // fire_empty is only consumed when the header stage is compiled out
`ifdef VC_TRACE_STREAMER_LINENUM_EN
   logic unused_ok;
   assign unused_ok = fire_empty;
`endif

endmodule

// File: tb/tb_vc_trace_streamer.sv
// tb_vc_trace_streamer: randomized self-checking bench for vc_trace_streamer.
// A reference model turns every accepted line into the exact byte sequence
// the sink must see (header, characters, newline) and a monitor compares the
// stream, the handshakes and stall stability cycle by cycle.
// Honors VC_TRACE_STREAMER_LINENUM_EN when compiled with it.

module tb_vc_trace_streamer;

   localparam int N = 512;

   logic clk;
   logic reset;

   vc_trace_streamer_if #(.p_nchars(N)) bus ();

   vc_trace_streamer #(.p_nchars(N)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   // Expected byte stream still owed by the DUT
   logic [7:0]  exp_q[$];
   logic [15:0] line_no;
   int          rdy_pct;

   logic        stalled;
   logic [7:0]  stall_msg;
   logic [7:0]  exp_byte;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: byte sequence for one accepted line
   task automatic push_line(input logic [N*8-1:0] m);
      logic [31:0] idx;
      int          lo;
`ifdef VC_TRACE_STREAMER_LINENUM_EN
      string       h;
      h = $sformatf("%04h", line_no);
      for (int i = 0; i < 4; i++) exp_q.push_back(h[i]);
      exp_q.push_back(8'h3A);
      exp_q.push_back(8'h20);
`endif
      idx = m[31:0];
      if (idx < 32'(N - 1)) begin
         lo = (idx < 32'd3) ? 4 : int'(idx) + 1;
         for (int k = N - 1; k >= lo; k--) exp_q.push_back(m[k*8 +: 8]);
      end
      exp_q.push_back(8'h0A);
      line_no = line_no + 16'd1;
   endtask

   // Monitor, sampling on the falling edge
   always @(negedge clk) begin
      if (reset) begin
         check("line_rdy_in_reset", bus.line_rdy, 1'b0);
         exp_q.delete();
         line_no = 16'h0000;
         stalled = 1'b0;
      end else begin
         check("out_val", bus.out_val, exp_q.size() != 0);
         check("line_rdy", bus.line_rdy, exp_q.size() == 0);
         if (stalled) check("stall_hold", bus.out_msg, stall_msg);
         if (bus.out_val && bus.out_rdy) begin
            if (exp_q.size() == 0) begin
               check("extra_char", bus.out_msg, 32'hFFFF_FFFF);
            end else begin
               exp_byte = exp_q.pop_front();
               check("char", bus.out_msg, exp_byte);
            end
         end
         stalled   = bus.out_val && !bus.out_rdy;
         stall_msg = bus.out_msg;
         if (bus.line_val && bus.line_rdy) push_line(bus.line_msg);
      end
   end

   // Sink readiness, redrawn every cycle
   always @(posedge clk) begin
      #1;
      bus.out_rdy = ($urandom_range(0, 99) < rdy_pct);
   end

   // Present a line and hold it until accepted; returns at posedge+1
   task automatic send_line(input logic [N*8-1:0] m);
      bit fired = 0;
      bus.line_val = 1'b1;
      bus.line_msg = m;
      for (int c = 0; c < 20000 && !fired; c++) begin
         @(negedge clk);
         if (bus.line_rdy) fired = 1;
         @(posedge clk);
         #1;
      end
      if (!fired) check("line_accept_timeout", 0, 1);
      bus.line_val = 1'b0;
   endtask

   // Wait until every expected byte has been seen and the DUT is idle
   task automatic wait_drain();
      bit done = 0;
      for (int c = 0; c < 20000 && !done; c++) begin
         @(negedge clk);
         if (exp_q.size() == 0 && bus.line_rdy) done = 1;
      end
      if (!done) check("drain_timeout", exp_q.size(), 0);
      @(posedge clk);
      #1;
   endtask

   // Line with random characters and a chosen write index
   task automatic make_line(input logic [31:0] idx, output logic [N*8-1:0] m);
      for (int k = 0; k < N; k++) m[k*8 +: 8] = 8'($urandom);
      m[31:0] = idx;
   endtask

   logic [N*8-1:0] msg;
   logic [31:0]    ridx;
   int             sel;

   initial begin
      reset        = 1'b1;
      bus.line_val = 1'b0;
      bus.line_msg = '0;
      bus.out_rdy  = 1'b0;
      rdy_pct      = 100;
      line_no      = 16'h0000;
      stalled      = 1'b0;
      stall_msg    = 8'h00;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      @(posedge clk);
      #1;

      // Two-character line "ab" streamed back-to-back with sink always ready
      make_line(32'd509, msg);
      msg[511*8 +: 8] = 8'h61;
      msg[510*8 +: 8] = 8'h62;
      send_line(msg);
      wait_drain();

      // Single-character lines "x", twice
      make_line(32'd510, msg);
      msg[511*8 +: 8] = 8'h78;
      send_line(msg);
      send_line(msg);
      wait_drain();

      // Empty lines: index at the top byte, beyond it, and all ones
      make_line(32'd511, msg);
      send_line(msg);
      make_line(32'd600, msg);
      send_line(msg);
      make_line(32'hFFFF_FFFF, msg);
      send_line(msg);
      wait_drain();

      // Clamped index values 0 and 2 and the smallest unclamped one
      make_line(32'd0, msg);
      send_line(msg);
      make_line(32'd2, msg);
      send_line(msg);
      make_line(32'd3, msg);
      send_line(msg);
      wait_drain();

      // Reset in the middle of a five-character line after its first char
      make_line(32'd506, msg);
      send_line(msg);
      @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      check("out_val_after_reset", bus.out_val, 1'b0);
      check("line_rdy_after_reset", bus.line_rdy, 1'b1);
      @(posedge clk);
      #1;
      make_line(32'd506, msg);
      send_line(msg);
      wait_drain();

      // 100 random lines back-to-back: first half free-flowing, then 30% ready
      for (int n = 0; n < 100; n++) begin
         rdy_pct = (n < 50) ? 100 : 30;
         sel = $urandom_range(0, 9);
         case (sel)
            0:       ridx = 32'($urandom_range(0, 2));
            1:       ridx = 32'(N - 1 + $urandom_range(0, 3));
            2:       ridx = $urandom;
            default: ridx = 32'($urandom_range(N - 60, N - 2));
         endcase
         make_line(ridx, msg);
         send_line(msg);
      end
      rdy_pct = 100;
      wait_drain();
      check("queue_empty_at_end", exp_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/vc_trace_streamer.md
# vc_trace_streamer

Hardware consumer of packed line-trace strings: accepts one trace line per val/rdy transaction, in the same packed format that trace tasks build (characters from the top byte downward, write index in the low 32 bits), and emits it as a byte-serial val/rdy character stream terminated by a newline. It sits between a design's trace-generation logic and a byte sink (UART TX, debug FIFO, host port), so line traces survive into FPGA/emulation builds where `$write` is unavailable.

## Interface

- `p_nchars`, 512, line buffer size in characters; `line_msg` is `p_nchars*8` bits; legal range 8..512
- `clk`  input  1  clock; all state updates on posedge
- `reset`  input  1  synchronous, active-high reset
- `line_val`  input  1  trace line valid
- `line_rdy`  output  1  streamer can accept a line
- `line_msg`  input  p_nchars*8  packed line: byte k at `[k*8+:8]`; first char at byte `p_nchars-1`; `[31:0]` = write index `idx` (next free byte)
- `out_val`  output  1  output character valid
- `out_rdy`  input  1  sink accepts character
- `out_msg`  output  8  ASCII character

## Operation

- Line fire: `line_val && line_rdy`. Char fire: `out_val && out_rdy`.
- Fire latches `line_msg` into a `p_nchars*8` buffer, sets `ptr = p_nchars-1`, computes `end`:
  - `idx >= p_nchars-1` (unsigned 32-bit): `end = p_nchars-1`, zero characters
  - `idx < 3`: clamp `end = 3`, since bytes 0..3 hold the index field
  - otherwise `end = idx`
- Characters emitted: bytes `p_nchars-1` down to `end+1`, count `p_nchars-1-end`. NUL and other bytes are passed through unchanged.
- FSM states:
  - IDLE: `line_rdy=1`, `out_val=0`. On fire, go to HDR if enabled, else BODY. If the line has zero characters, go to EOL.
  - HDR: see Configuration.
  - BODY: `out_val=1`, `out_msg=buf[ptr*8+:8]`. On char fire, `ptr--`. Char fire with `ptr==end+1` goes to EOL.
  - EOL: `out_val=1`, `out_msg=8'h0A`. On char fire, go to IDLE.
- `line_rdy` is asserted only in IDLE. A new line is never accepted while one is streaming.
- While `out_val=1 && out_rdy=0`, `out_msg` and all state hold stable.
- `out_val` never drops without a char fire, except on reset.

## Timing

- Reset values: state IDLE, `out_val=0`, `ptr=p_nchars-1`, line counter 0. `line_rdy=0` in any cycle where `reset=1`.
- Reset mid-line: the line is abandoned with no newline. `out_val=0` the cycle after reset is sampled.
- Latency: line fire in cycle N gives the first character (or header digit, or 0x0A) with `out_val=1` in cycle N+1.
- With `out_rdy` held at 1, an L-character line occupies 1 + L + 1 cycles (+6 with header) from fire to IDLE. The next line fires in the IDLE cycle, so there is one output bubble between lines.
- `line_msg` is sampled only on fire. Changes after fire have no effect.

## Configuration

- `VC_TRACE_STREAMER_LINENUM_EN` defined:
  - A 16-bit line counter increments on every line fire and wraps 0xFFFF to 0x0000. The first line after reset is numbered 0.
  - HDR state emits 6 characters before BODY: 4 lowercase hex digits of the counter value latched at fire (MSB first), then ':' (0x3A), then ' ' (0x20).
  - After HDR, go to BODY, or to EOL if the line has zero characters.
- Macro undefined: no HDR state and no counter. IDLE transitions directly to BODY or EOL.

## Test plan

- `p_nchars=16`, bytes 15='a', 14='b', `idx=13`, `out_rdy=1` -> 'a'(0x61), 'b'(0x62), 0x0A on consecutive cycles N+1..N+3; `line_rdy` returns at N+4.
- Empty line, `idx=15` -> single 0x0A. `idx=0` -> 12 characters from bytes 15..4, then 0x0A.
- Backpressure: `out_rdy` random at 30% -> identical byte sequence, `out_msg` stable during stalls, no drop or duplicate; `line_val` held high is not accepted until IDLE.
- Reset asserted in BODY after 1 of 5 characters -> `out_val=0` next cycle, no 0x0A, `line_rdy=1` the cycle after reset deasserts; the next line streams from its first character.
- With `VC_TRACE_STREAMER_LINENUM_EN`, two lines "x" -> "0000: x\n" then "0001: x\n". After 65536 lines, the counter wraps to header "0000".
- Back-to-back 100 random lines at `p_nchars=512` against a golden model -> exact byte match, including the clamp and empty-line cases.
